pulse_burst_gen: RTL and testbench

- Moore-style FSM transmitter that emits a programmed number of single-cycle pulses, with a programmable idle gap between pulses.
- It is the driving end of the pulse-counting interface: its x_out connects directly to the x (count-enable) input of the team's pulse-counting FSMs.
- It is used to stimulate and step counters under control of a sequencer, with a start/busy/done handshake.

---
 rtl/pulse_burst_pkg.sv | 15 +
 rtl/burst_down_counter.sv | 27 ++
 rtl/pulse_burst_gen.sv | 88 ++++++++
 tb/tb_pulse_burst_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_burst_pkg.sv
// Shared definitions for the pulse burst transmitter: state encoding and default field widths.
package pulse_burst_pkg;

    localparam int STATE_W   = 2;
    localparam int CNT_W_DEF = 8;
    localparam int GAP_W_DEF = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/burst_down_counter.sv
// Loadable down counter that saturates at zero; used for both the pulse count and the gap count.
module burst_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         is_one
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && value != '0) begin
            value <= value - W'(1);
        end
    end

    assign is_one = (value == W'(1));

endmodule

// File: rtl/pulse_burst_gen.sv
// Moore FSM that emits a programmed number of single-cycle pulses on x_out with a programmable idle gap.
module pulse_burst_gen
    import pulse_burst_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    state_t           state;
    logic [GAP_W-1:0] gap_lat;
    logic [GAP_W-1:0] gap_val;
    logic             cnt_is_one;
    logic             gap_is_one;
    logic             cnt_load;
    logic             gap_load;
    logic             accept;

    assign accept   = (state == IDLE) && start;
    assign cnt_load = accept && (count != '0);
    assign gap_load = (state == PULSE) && !cnt_is_one && (gap_lat != '0);

    burst_down_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (count),
        .dec      (state == PULSE),
        .value    (remaining),
        .is_one   (cnt_is_one)
    );

    burst_down_counter #(.W(GAP_W)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_lat),
        .dec      (state == GAP),
        .value    (gap_val),
        .is_one   (gap_is_one)
    );

    // NOTE: async reset clears the state register, so the Moore output decodes drop without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gap_lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gap_lat <= gap;
                        state   <= (count != '0) ? PULSE : DONE;
                    end
                end
                PULSE: begin
                    if (cnt_is_one)
                        state <= DONE;
                    else if (gap_lat == '0)
                        state <= PULSE;
                    else
                        state <= GAP;
                end
                // A zero gap counter can only appear after corruption; leave rather than stall.
                GAP: begin
                    if (gap_is_one || gap_val == '0)
                        state <= PULSE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign x_out = (state == PULSE);
    assign done  = (state == DONE);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Randomized self-checking bench for pulse_burst_gen against a cycle-sequence reference model.
module tb_pulse_burst_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] count = '0;
    logic [3:0] gap = '0;
    logic       x_out;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    int total = 0;
    int bad   = 0;
    int rise_cnt = 0;
    logic prev_x = 1'b0;

    // expected per-cycle {x_out, busy, done, remaining}
    logic [10:0] exp_q[$];

    pulse_burst_gen #(.CNT_W(8), .GAP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .gap       (gap),
        .x_out     (x_out),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    // Model: N pulses separated by G idle cycles, one done cycle; remaining counts pulses not yet finished.
    task automatic append_burst(input int n, input int g);
        if (n == 0) begin
            exp_q.push_back({1'b0, 1'b1, 1'b1, 8'd0});
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({1'b1, 1'b1, 1'b0, 8'(n - i)});
                if (i < n - 1)
                    for (int j = 0; j < g; j++)
                        exp_q.push_back({1'b0, 1'b1, 1'b0, 8'(n - i - 1)});
            end
            exp_q.push_back({1'b0, 1'b1, 1'b1, 8'd0});
        end
    endtask

    task automatic append_idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            exp_q.push_back(11'd0);
    endtask

    task automatic check_cycles(input string name, input int cycles);
        logic [10:0] exp_v;
        logic [10:0] obs;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 11'd0;
            obs   = {x_out, busy, done, remaining};
            if (x_out === 1'b1 && prev_x !== 1'b1)
                rise_cnt++;
            prev_x = x_out;
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL %s cycle %0d: got x=%b busy=%b done=%b rem=%0d, want x=%b busy=%b done=%b rem=%0d",
                         name, c, obs[10], obs[9], obs[8], obs[7:0],
                         exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
        end
    endtask

    // Request at negedge, accepted at the following edge (edge 0); cycle 1 is checked next.
    task automatic start_burst(input int n, input int g, input bit hold);
        @(negedge clk);
        start = 1'b1;
        count = 8'(n);
        gap   = 4'(g);
        @(posedge clk);
        #1;
        if (!hold) begin
            start = 1'b0;
            count = 8'($urandom);
            gap   = 4'($urandom);
        end
    endtask

    task automatic run_burst(input string name, input int n, input int g);
        int len;
        exp_q.delete();
        append_burst(n, g);
        append_idle(1);
        len = exp_q.size();
        start_burst(n, g, 1'b0);
        check_cycles(name, len);
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({x_out, busy, done, remaining} !== 11'd0) begin
            bad++;
            $display("FAIL reset_async: got x=%b busy=%b done=%b rem=%0d, want all 0",
                     x_out, busy, done, remaining);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        append_idle(3);
        check_cycles("reset_hold", 3);
    endtask

    task automatic test_gap0();
        run_burst("gap0_n3", 3, 0);
    endtask

    task automatic test_gap();
        rise_cnt = 0;
        run_burst("gap2_n4", 4, 2);
        total++;
        if (rise_cnt !== 4) begin
            bad++;
            $display("FAIL gap2_rises: got %0d rising edges, want 4", rise_cnt);
        end
    endtask

    task automatic test_zero();
        run_burst("zero_count", 0, int'($urandom_range(0, 15)));
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_burst("random", int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        append_burst(2, 1);
        append_idle(1);
        append_burst(2, 1);
        append_idle(1);
        start_burst(2, 1, 1'b1);
        check_cycles("b2b", 1);
        count = 8'd7;
        check_cycles("b2b", 2);
        count = 8'd2;
        check_cycles("b2b", 3);
        start = 1'b0;
        count = 8'd7;
        check_cycles("b2b", 4);
    endtask

    task automatic test_abort();
        exp_q.delete();
        append_burst(5, 3);
        start_burst(5, 3, 1'b0);
        check_cycles("abort_pre", 3);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({x_out, busy, done, remaining} !== 11'd0) begin
            bad++;
            $display("FAIL abort_async: got x=%b busy=%b done=%b rem=%0d, want all 0",
                     x_out, busy, done, remaining);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        append_idle(6);
        check_cycles("abort_quiet", 6);
        rise_cnt = 0;
        run_burst("max_count", 255, 0);
        total++;
        if (rise_cnt !== 1) begin
            bad++;
            $display("FAIL max_rises: got %0d rising edges, want 1 continuous run", rise_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_gap0();
        test_gap();
        test_zero();
        test_back_to_back();
        test_random();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
